// File: rtl/div_restore_seq.sv
// Purpose: multi-cycle unsigned restoring divider driving an external shared subtractor.
// Latency: WIDTH+1 clocks from accepted start to the done pulse; 1 clock when the divisor is zero.
// Backpressure: none; start is sampled only in IDLE, and results are held until the next done.
//
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   start, dividend, divisor  request and operands (sampled together in IDLE)
//   busy, done, div_zero      status: iterating, one-cycle result pulse, last op divided by zero
//   quotient, remainder       registered results, updated only as done rises
//   sub_a, sub_b, sub_en      trial remainder / divisor / enable towards the subtractor
//   sub_diff, sub_borrow      difference and borrow returned by the subtractor
module div_restore_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  output logic             sub_en,
  input  logic [WIDTH-1:0] sub_diff,
  input  logic             sub_borrow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_rem,   w_rem_nxt;
  logic [WIDTH-1:0] r_q,     w_q_nxt;
  logic [WIDTH-1:0] r_d,     w_d_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic [WIDTH-1:0] r_quot,  w_quot_nxt;
  logic [WIDTH-1:0] r_remo,  w_remo_nxt;
  logic             r_dz,    w_dz_nxt;

  logic [WIDTH-1:0] w_shift;
  logic             w_take;
  logic [WIDTH-1:0] w_rem_iter;
  logic [WIDTH-1:0] w_q_iter;
  logic             w_run;

  // Shift the next dividend bit into the partial remainder.
  assign w_shift    = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
  // If the bit shifted out of R was set, the true shifted value is >= 2^WIDTH,
  // so it always exceeds D; the borrow of the WIDTH-bit subtract is then
  // meaningless, but the low WIDTH bits of the difference are still exact.
  assign w_take     = r_rem[WIDTH-1] | ~sub_borrow;
  assign w_rem_iter = w_take ? sub_diff : w_shift;
  assign w_q_iter   = {r_q[WIDTH-2:0], w_take};

  assign w_run      = (r_state == S_RUN);
  assign busy       = w_run;
  assign done       = (r_state == S_DONE);
  assign sub_en     = w_run;
  assign sub_a      = w_run ? w_shift : '0;
  assign sub_b      = w_run ? r_d     : '0;
  assign quotient   = r_quot;
  assign remainder  = r_remo;
  assign div_zero   = r_dz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_q     <= w_q_nxt;
      r_d     <= w_d_nxt;
      r_cnt   <= w_cnt_nxt;
      r_quot  <= w_quot_nxt;
      r_remo  <= w_remo_nxt;
      r_dz    <= w_dz_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_q_nxt     = r_q;
    w_d_nxt     = r_d;
    w_cnt_nxt   = r_cnt;
    w_quot_nxt  = r_quot;
    w_remo_nxt  = r_remo;
    w_dz_nxt    = r_dz;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_rem_nxt = '0;
          w_q_nxt   = dividend;
          w_d_nxt   = divisor;
          w_cnt_nxt = '0;
          if (divisor == '0) begin
            // Division by zero bypasses iteration entirely.
            w_quot_nxt  = '1;
            w_remo_nxt  = dividend;
            w_dz_nxt    = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        w_rem_nxt = w_rem_iter;
        w_q_nxt   = w_q_iter;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_quot_nxt  = w_q_iter;
          w_remo_nxt  = w_rem_iter;
          w_dz_nxt    = 1'b0;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_div_restore_seq.sv
// Purpose: randomized self-checking bench for div_restore_seq against an arithmetic model.
// Latency: each operation is followed from start to done plus one cycle.
// Backpressure: none; the subtractor is modelled combinationally.
module tb_div_restore_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic       div_zero;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic [7:0] sub_a;
  logic [7:0] sub_b;
  logic       sub_en;
  logic [7:0] sub_diff;
  logic       sub_borrow;

  int n_checks = 0;
  int n_fail   = 0;

  // Held-result model
  logic [7:0] prev_q  = 8'd0;
  logic [7:0] prev_r  = 8'd0;
  logic       prev_dz = 1'b0;

  always #5 clk = ~clk;

  // Stand-in for the shared 8-bit subtractor
  assign sub_diff   = sub_a - sub_b;
  assign sub_borrow = (sub_a < sub_b);

  div_restore_seq #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .quotient   (quotient),
    .remainder  (remainder),
    .sub_a      (sub_a),
    .sub_b      (sub_b),
    .sub_en     (sub_en),
    .sub_diff   (sub_diff),
    .sub_borrow (sub_borrow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE after the op.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit hold_start);
    logic [7:0] exp_q, exp_r;
    logic       exp_dz;
    int busy_n, en_n, done_at, en_bad, stable_bad;
    string t;
    t = $sformatf("%0d/%0d", a, b);
    if (b == 8'd0) begin
      exp_q = 8'hFF; exp_r = a; exp_dz = 1'b1;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_dz = 1'b0;
    end
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    // Scramble operands; the DUT must not resample them
    dividend = 8'($urandom); divisor = 8'($urandom);
    busy_n = 0; en_n = 0; done_at = 0; en_bad = 0; stable_bad = 0;
    for (int c = 1; c <= 20 && done_at == 0; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (sub_en) en_n++;
      if (sub_en !== busy) en_bad++;
      if (done) done_at = c;
      else if (quotient !== prev_q || remainder !== prev_r || div_zero !== prev_dz)
        stable_bad++;
    end
    chk({"done_lat ", t}, done_at, (b == 8'd0) ? 1 : 9);
    chk({"busy_cyc ", t}, busy_n, (b == 8'd0) ? 0 : 8);
    chk({"sub_en_cyc ", t}, en_n, (b == 8'd0) ? 0 : 8);
    chk({"sub_en_busy ", t}, en_bad, 0);
    chk({"held_before_done ", t}, stable_bad, 0);
    chk({"quot ", t}, quotient, exp_q);
    chk({"rem ", t}, remainder, exp_r);
    chk({"div_zero ", t}, div_zero, exp_dz);
    prev_q = exp_q; prev_r = exp_r; prev_dz = exp_dz;
    // One cycle later: back in IDLE, done dropped, subtractor idle, results held
    @(negedge clk);
    chk({"done_pulse ", t}, done, 0);
    chk({"busy_after ", t}, busy, 0);
    chk({"sub_idle ", t}, {sub_en, sub_a, sub_b}, 0);
    chk({"quot_held ", t}, quotient, exp_q);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {busy, done, div_zero, quotient, remainder, sub_a, sub_b, sub_en}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(8'd200, 8'd7,   1'b0);
    run_op(8'd255, 8'd255, 1'b0);
    run_op(8'd255, 8'd200, 1'b0);
    run_op(8'd5,   8'd9,   1'b0);
    run_op(8'd255, 8'd1,   1'b0);
    run_op(8'd100, 8'd0,   1'b0);

    // Reset during RUN cycle 4 of 200/7
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {busy, done, div_zero, quotient, remainder, sub_a, sub_b, sub_en}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_q = 8'd0; prev_r = 8'd0; prev_dz = 1'b0;
    begin
      int dn = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (done || busy) dn++;
      end
      chk("rst_no_done", dn, 0);
    end
    run_op(8'd9, 8'd3, 1'b0);

    // start held across op and DONE, then an immediate next op
    run_op(8'd77, 8'd5, 1'b1);
    run_op(8'd143, 8'd11, 1'b0);

    // Randomized
    for (int i = 0; i < 60; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 8'd0;
        1:       b = 8'($urandom_range(1, 15));
        2:       b = 8'($urandom_range(128, 255));
        default: b = 8'($urandom);
      endcase
      run_op(a, b, ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
